// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning the architectural HI/LO registers.
// mult/multu/div/divu run for a fixed number of cycles with busy high;
// mthi/mtlo write in a single edge without raising busy.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] RsInE,
    input  logic [31:0] RtInE,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               busy_q, busy_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a, abs_b;
    logic [31:0]        quot_mag, rem_mag;
    logic [31:0]        quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;

    // Result datapath on the latched operands; divide uses magnitudes so INT_MIN/-1 wraps cleanly.
    always_comb begin
        prod_s   = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        abs_a    = a_q[31] ? (32'd0 - a_q) : a_q;
        abs_b    = b_q[31] ? (32'd0 - b_q) : b_q;
        quot_mag = abs_a / abs_b;
        rem_mag  = abs_a % abs_b;
        quot_s   = (a_q[31] ^ b_q[31]) ? (32'd0 - quot_mag) : quot_mag;
        rem_s    = a_q[31] ? (32'd0 - rem_mag) : rem_mag;
        quot_u   = a_q / b_q;
        rem_u    = a_q % b_q;
    end

    // Next-state, operand capture, counter and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (md_op_e'(mdop))
                        OP_MULT, OP_MULTU: begin
                            op_d    = md_op_e'(mdop);
                            a_d     = RsInE;
                            b_d     = RtInE;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = md_op_e'(mdop);
                            a_d     = RsInE;
                            b_d     = RtInE;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = RsInE;
                        OP_MTLO: lo_d = RsInE;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    unique case (op_q)
                        OP_MULT: begin
                            hi_d = prod_s[63:32];
                            lo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_u[63:32];
                            lo_d = prod_u[31:0];
                        end
                        OP_DIV: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_s;
                                lo_d = quot_s;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_u;
                                lo_d = quot_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and architectural registers; reset aborts any running operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
